// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN layer control blocks.
//   state_e      : filter bank sequencer state, 3-bit encoding
//   KERNEL_WORDS : weights per filter (2x2 kernel)
//   DEF_*        : default widths/counts used by the sequencer parameters
package cnn_ctrl_pkg;

  localparam int KERNEL_WORDS    = 4;
  localparam int DEF_DW          = 16;
  localparam int DEF_NUM_FILTERS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_LAUNCH  = 3'd3,
    ST_WAIT    = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

endpackage

// File: rtl/filter_weight_select.sv
// Combinational slice mux: picks the kernel words and bias of one filter
// out of the flat filter-bank read buses.
//   mem_rdata : all filters' weights, filter f / word k at [(4f+k)*DW +: DW]
//   mem_bias  : all filters' biases, filter f at [f*DW +: DW]
//   idx       : filter to select (out-of-range index yields zeros)
//   wts       : selected kernel words
//   bias      : selected bias
module filter_weight_select
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int DW          = DEF_DW,
  parameter int IDX_W       = 4
) (
  input  logic [NUM_FILTERS*KERNEL_WORDS*DW-1:0] mem_rdata,
  input  logic [NUM_FILTERS*DW-1:0]              mem_bias,
  input  logic [IDX_W-1:0]                       idx,
  output logic [KERNEL_WORDS-1:0][DW-1:0]        wts,
  output logic [DW-1:0]                          bias
);

  always_comb begin
    wts  = '0;
    bias = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      if (idx == IDX_W'(f)) begin
        for (int k = 0; k < KERNEL_WORDS; k++)
          wts[k] = mem_rdata[(f*KERNEL_WORDS + k)*DW +: DW];
        bias = mem_bias[f*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/filter_bank_sequencer.sv
// Sequences a bank of filter-weight memories into one shared conv engine.
// On start, each filter in turn is fetched (one-hot mem_en for one cycle),
// its weights/bias are captured, a conv pass is launched and the sequencer
// waits for conv_done before moving on. done pulses once after the last
// filter; abort returns to IDLE from anywhere without a done.
//   clk, rst_n     : clock, async active-low reset
//   start, abort   : layer control (start only honoured in IDLE)
//   mem_en         : one-hot filter memory read enable
//   mem_rdata/bias : registered memory outputs for all filters
//   w0..w3, bias   : captured kernel words and bias for the engine
//   filter_idx     : filter currently loaded
//   conv_start     : one-cycle conv launch pulse
//   conv_done      : engine completion pulse (only looked at in WAIT)
//   busy, done     : status; done is a one-cycle pulse
module filter_bank_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int DW          = DEF_DW,
  parameter int IDX_W       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  output logic [NUM_FILTERS-1:0]                 mem_en,
  input  logic [NUM_FILTERS*KERNEL_WORDS*DW-1:0] mem_rdata,
  input  logic [NUM_FILTERS*DW-1:0]              mem_bias,
  output logic [DW-1:0]                          w0,
  output logic [DW-1:0]                          w1,
  output logic [DW-1:0]                          w2,
  output logic [DW-1:0]                          w3,
  output logic [DW-1:0]                          bias,
  output logic [IDX_W-1:0]                       filter_idx,
  output logic                                   conv_start,
  input  logic                                   conv_done,
  output logic                                   busy,
  output logic                                   done
);

  state_e                          state, state_n;
  logic [IDX_W-1:0]                idx_n;
  logic                            last;
  logic [NUM_FILTERS-1:0]          fetch_oh;
  logic [KERNEL_WORDS-1:0][DW-1:0] sel_w;
  logic [DW-1:0]                   sel_b;
  logic [KERNEL_WORDS-1:0][DW-1:0] w_q;
  logic [DW-1:0]                   b_q;

  assign last = (filter_idx == IDX_W'(NUM_FILTERS - 1));

  filter_weight_select #(
    .NUM_FILTERS (NUM_FILTERS),
    .DW          (DW),
    .IDX_W       (IDX_W)
  ) u_sel (
    .mem_rdata (mem_rdata),
    .mem_bias  (mem_bias),
    .idx       (filter_idx),
    .wts       (sel_w),
    .bias      (sel_b)
  );

  // Next state / next index. abort overrides everything, including a
  // coincident start or conv_done.
  always_comb begin
    state_n = state;
    idx_n   = filter_idx;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_n = ST_FETCH;
            idx_n   = '0;
          end
        end
        ST_FETCH:   state_n = ST_CAPTURE;
        ST_CAPTURE: state_n = ST_LAUNCH;
        ST_LAUNCH:  state_n = ST_WAIT;
        ST_WAIT: begin
          if (conv_done) begin
            if (last) begin
              state_n = ST_FINISH;
            end else begin
              state_n = ST_FETCH;
              idx_n   = filter_idx + IDX_W'(1);
            end
          end
        end
        ST_FINISH:  state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  // Read enable for the filter about to be fetched.
  always_comb begin
    fetch_oh = '0;
    if (state_n == ST_FETCH) begin
      for (int f = 0; f < NUM_FILTERS; f++)
        if (idx_n == IDX_W'(f)) fetch_oh[f] = 1'b1;
    end
  end

  // Outputs are registered from the next state so each one lines up with
  // the state it belongs to, with no decode glitches on the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      filter_idx <= '0;
      mem_en     <= '0;
      conv_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      filter_idx <= idx_n;
      mem_en     <= fetch_oh;
      conv_start <= (state_n == ST_LAUNCH);
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_FINISH);
    end
  end

  // Weights only move on the CAPTURE edge; the memory output is valid in
  // CAPTURE because it registered during FETCH. An abort in CAPTURE keeps
  // the previous set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      b_q <= '0;
    end else if (state == ST_CAPTURE && !abort) begin
      w_q <= sel_w;
      b_q <= sel_b;
    end
  end

  assign w0   = w_q[0];
  assign w1   = w_q[1];
  assign w2   = w_q[2];
  assign w3   = w_q[3];
  assign bias = b_q;

endmodule

// File: tb/tb_filter_bank_sequencer.sv
// Self-checking bench for filter_bank_sequencer. The expected behaviour of
// a whole run is computed up front as a cycle schedule (fetch, launch and
// done cycles derived from per-filter conv latencies) and every cycle of
// the DUT is compared against that schedule.
module tb_filter_bank_sequencer;
  import cnn_ctrl_pkg::*;

  localparam int NF = 4;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // 4-filter DUT
  logic              start, abort, conv_done;
  logic [NF*4*DW-1:0] mem_rdata;
  logic [NF*DW-1:0]   mem_bias;
  logic [NF-1:0]      mem_en;
  logic [DW-1:0]      w0, w1, w2, w3, bias;
  logic [IW-1:0]      filter_idx;
  logic               conv_start, busy, done;

  // 1-filter DUT
  logic               s_start, s_abort, s_conv_done;
  logic [4*DW-1:0]    s_mem_rdata;
  logic [DW-1:0]      s_mem_bias;
  logic [0:0]         s_mem_en;
  logic [DW-1:0]      s_w0, s_w1, s_w2, s_w3, s_bias;
  logic [IW-1:0]      s_filter_idx;
  logic               s_conv_start, s_busy, s_done;

  logic [DW-1:0] wts [NF][4];
  logic [DW-1:0] bs  [NF];
  logic [DW-1:0] s_wts [4];
  logic [DW-1:0] s_bs;

  filter_bank_sequencer #(.NUM_FILTERS(NF), .DW(DW), .IDX_W(IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mem_en(mem_en), .mem_rdata(mem_rdata), .mem_bias(mem_bias),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .bias(bias),
    .filter_idx(filter_idx), .conv_start(conv_start), .conv_done(conv_done),
    .busy(busy), .done(done)
  );

  filter_bank_sequencer #(.NUM_FILTERS(1), .DW(DW), .IDX_W(IW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .mem_en(s_mem_en), .mem_rdata(s_mem_rdata), .mem_bias(s_mem_bias),
    .w0(s_w0), .w1(s_w1), .w2(s_w2), .w3(s_w3), .bias(s_bias),
    .filter_idx(s_filter_idx), .conv_start(s_conv_start), .conv_done(s_conv_done),
    .busy(s_busy), .done(s_done)
  );

  // Registered filter memories: a slice shows real data only in the cycle
  // after its enable was high, inverted garbage otherwise.
  always @(posedge clk) begin
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < 4; k++)
        mem_rdata[(4*f+k)*DW +: DW] <= mem_en[f] ? wts[f][k] : ~wts[f][k];
      mem_bias[f*DW +: DW] <= mem_en[f] ? bs[f] : ~bs[f];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      s_mem_rdata[k*DW +: DW] <= s_mem_en[0] ? s_wts[k] : ~s_wts[k];
    s_mem_bias <= s_mem_en[0] ? s_bs : ~s_bs;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < 4; k++)
        wts[f][k] = rnd ? DW'($urandom) : {4'h0, 4'(f), 4'h0, 4'(k)};
      bs[f] = rnd ? DW'($urandom) : {4'h0, 4'(f), 8'hB0};
    end
  endtask

  task automatic chk_w(input string tag, input int f);
    chk({tag, "_w0"}, w0, wts[f][0]);
    chk({tag, "_w1"}, w1, wts[f][1]);
    chk({tag, "_w2"}, w2, wts[f][2]);
    chk({tag, "_w3"}, w3, wts[f][3]);
    chk({tag, "_bias"}, bias, bs[f]);
  endtask

  task automatic chk_quiet(input string tag, input int idx);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_conv_start"}, conv_start, 1'b0);
    chk({tag, "_mem_en"}, mem_en, '0);
    chk({tag, "_idx"}, filter_idx, idx);
  endtask

  // One full pass over the bank, started in the current cycle.
  // lat[f]: cycles from filter f's conv_start to its conv_done.
  // noise: also raise conv_done during every LAUNCH cycle.
  // poke : raise start in filter 0 FETCH and filter 1 WAIT.
  // abort_f / rst_f >= 0: abort / async reset in WAIT of that filter.
  task automatic run(input int lat[NF], input bit noise, input bit poke,
                     input int abort_f, input int rst_f);
    int cs[NF];
    int dn;
    cs[0] = 3;
    for (int f = 1; f < NF; f++) cs[f] = cs[f-1] + lat[f-1] + 3;
    dn = cs[NF-1] + lat[NF-1] + 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= dn + 1; t++) begin
      logic [NF-1:0] e_me;
      int e_idx;
      bit e_cs;
      int cur;
      e_me = '0; e_idx = 0; e_cs = 1'b0; cur = -1;
      for (int f = 0; f < NF; f++) begin
        if (t == cs[f] - 2) e_me[f] = 1'b1;
        if (f > 0 && t >= cs[f] - 2) e_idx = f;
        if (t == cs[f]) e_cs = 1'b1;
        if (t >= cs[f] && t <= cs[f] + lat[f]) cur = f;
      end
      chk("mem_en", mem_en, e_me);
      chk("filter_idx", filter_idx, e_idx);
      chk("conv_start", conv_start, e_cs);
      chk("done", done, t == dn);
      chk("busy", busy, t <= dn);
      if (cur >= 0) chk_w("launch", cur);
      if (t == dn + 1) break;

      conv_done = 1'b0;
      for (int f = 0; f < NF; f++)
        if (t == cs[f] + lat[f]) conv_done = 1'b1;
      if (noise && e_cs) conv_done = 1'b1;
      start = poke && (t == cs[0] - 2 || t == cs[1] + 1);

      if (abort_f >= 0 && t == cs[abort_f] + 1) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        conv_done = 1'b0;
        start = 1'b0;
        chk_quiet("abort", abort_f);
        chk_w("abort_hold", abort_f);
        for (int i = 0; i < 3; i++) begin
          step();
          chk_quiet("post_abort", abort_f);
        end
        return;
      end
      if (rst_f >= 0 && t == cs[rst_f] + 1) begin
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("async_rst", 0);
        chk("async_rst_w0", w0, '0);
        chk("async_rst_w3", w3, '0);
        chk("async_rst_bias", bias, '0);
        conv_done = 1'b0;
        start = 1'b0;
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          conv_done = (i == 1);
          step();
          chk_quiet("post_rst", 0);
        end
        conv_done = 1'b0;
        return;
      end
      step();
    end
    conv_done = 1'b0;
    start = 1'b0;
  endtask

  task automatic rand_lat(output int lat[NF], input int lo);
    for (int f = 0; f < NF; f++) lat[f] = int'($urandom_range(8, lo));
  endtask

  initial begin
    int L[NF];
    int sl;
    start = 0; abort = 0; conv_done = 0;
    s_start = 0; s_abort = 0; s_conv_done = 0;
    fill_mem(1'b0);
    for (int k = 0; k < 4; k++) s_wts[k] = DW'($urandom);
    s_bs = DW'($urandom);

    // reset state
    step();
    step();
    chk_quiet("reset", 0);
    chk("reset_w0", w0, '0);
    chk("reset_bias", bias, '0);
    rst_n = 1'b1;
    step();
    chk_quiet("after_reset", 0);

    // conv_done in IDLE must not do anything
    conv_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("idle_conv_done", 0);
    end
    conv_done = 1'b0;

    // pattern weights, fixed 5-cycle engine: done lands 33 cycles after start
    for (int f = 0; f < NF; f++) L[f] = 5;
    run(L, 1'b0, 1'b0, -1, -1);

    // back-to-back random runs
    fill_mem(1'b1);
    rand_lat(L, 1);
    run(L, 1'b0, 1'b0, -1, -1);
    rand_lat(L, 1);
    run(L, 1'b0, 1'b0, -1, -1);

    // conv_done held in LAUNCH, start pokes while busy
    step();
    fill_mem(1'b1);
    rand_lat(L, 1);
    run(L, 1'b1, 1'b1, -1, -1);

    // abort in WAIT of filter 2, then restart from filter 0
    step();
    rand_lat(L, 2);
    run(L, 1'b0, 1'b0, 2, -1);
    fill_mem(1'b1);
    rand_lat(L, 1);
    run(L, 1'b0, 1'b0, -1, -1);

    // async reset in WAIT of filter 1, then a clean run
    step();
    rand_lat(L, 2);
    run(L, 1'b0, 1'b0, -1, 1);
    rand_lat(L, 1);
    run(L, 1'b0, 1'b0, -1, -1);

    // single-filter bank
    sl = int'($urandom_range(6, 2));
    step();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("nf1_mem_en", s_mem_en, 1'b1);
    chk("nf1_busy", s_busy, 1'b1);
    step();
    chk("nf1_capture_mem_en", s_mem_en, 1'b0);
    chk("nf1_capture_cs", s_conv_start, 1'b0);
    step();
    chk("nf1_conv_start", s_conv_start, 1'b1);
    chk("nf1_idx", s_filter_idx, 0);
    chk("nf1_w0", s_w0, s_wts[0]);
    chk("nf1_w1", s_w1, s_wts[1]);
    chk("nf1_w2", s_w2, s_wts[2]);
    chk("nf1_w3", s_w3, s_wts[3]);
    chk("nf1_bias", s_bias, s_bs);
    for (int i = 1; i < sl; i++) begin
      step();
      chk("nf1_wait_done", s_done, 1'b0);
      chk("nf1_wait_busy", s_busy, 1'b1);
      chk("nf1_wait_cs", s_conv_start, 1'b0);
    end
    step();
    s_conv_done = 1'b1;
    step();
    s_conv_done = 1'b0;
    chk("nf1_done", s_done, 1'b1);
    chk("nf1_done_busy", s_busy, 1'b1);
    chk("nf1_done_mem_en", s_mem_en, 1'b0);
    step();
    chk("nf1_end_done", s_done, 1'b0);
    chk("nf1_end_busy", s_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
